// File: rtl/ssha3_seq.sv
// Keccak plane walker: steps (x, y) over one command, turns each coordinate into
// a lane byte address through ssha3, and streams it out as a registered slice.

module ssha3 (
  input  logic [2:0] i_rs1,
  input  logic [2:0] i_rs2,
  input  logic       i_f_xy,
  input  logic       i_f_x1,
  input  logic       i_f_x2,
  input  logic       i_f_x4,
  input  logic       i_f_yx,
  output logic [4:0] o_idx
);

  logic [5:0] w_sum;
  logic [2:0] w_r;
  logic [5:0] w_r4;
  logic [5:0] w_r5;
  logic [5:0] w_k;
  logic [5:0] w_xk;
  logic [5:0] w_x;
  logic [5:0] w_y;

  assign w_x   = {3'b000, i_rs1};
  assign w_y   = {3'b000, i_rs2};
  // r = (2x + 3y) mod 5; 6 bits keeps 2*7 + 3*7 from overflowing
  assign w_sum = {2'b00, i_rs1, 1'b0} + w_y + {2'b00, i_rs2, 1'b0};
  assign w_r   = 3'(w_sum % 6'd5);
  assign w_r4  = {1'b0, w_r, 2'b00};
  assign w_r5  = w_r4 + {3'b000, w_r};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_k   = 6'd0;
    o_idx = 5'd0;
    if (i_f_x1) w_k = 6'd1;
    if (i_f_x2) w_k = 6'd2;
    if (i_f_x4) w_k = 6'd4;
    w_xk = (w_x + w_k) % 6'd5;
    if (i_f_xy) begin
      o_idx = 5'(w_x + w_r4 + w_y);
    end else if (i_f_x1 || i_f_x2 || i_f_x4) begin
      o_idx = 5'(w_xk + w_r4 + w_y);
    end else if (i_f_yx) begin
      o_idx = 5'(w_y + w_r5);
    end
  end

endmodule

module ssha3_seq #(
  parameter int ADDR_W = 32,
  parameter int ROWS   = 5
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic              cmd_abort,
  output logic              off_valid,
  input  logic              off_ready,
  output logic [ADDR_W-1:0] off_addr,
  output logic [2:0]        off_x,
  output logic [2:0]        off_y,
  output logic              off_last,
  output logic              done,
  output logic              err_op
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_XY = 3'd0,
    OP_X1 = 3'd1,
    OP_X2 = 3'd2,
    OP_X4 = 3'd3,
    OP_YX = 3'd4
  } op_e;

  localparam logic [2:0] LAST_Y = 3'(ROWS - 1);

  state_e            r_state;
  state_e            w_next_state;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_x;
  logic [2:0]        r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;
  logic              r_done;
  logic              r_err_op;

  logic              w_op_legal;
  logic              w_start;
  logic              w_advance;
  logic              w_finish;
  logic              w_err;
  logic [2:0]        w_op_sel;
  logic [ADDR_W-1:0] w_base_sel;
  logic [2:0]        w_nx;
  logic [2:0]        w_ny;
  logic [4:0]        w_idx;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_next_last;

  assign w_op_legal = (cmd_op <= OP_YX);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    w_err        = 1'b0;
    cmd_ready    = 1'b0;
    off_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_op_legal) begin
            w_next_state = S_RUN;
            w_start      = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_RUN: begin
        off_valid = 1'b1;
        // A handshake coinciding with abort is simply the last delivered beat.
        if (cmd_abort || (off_ready && r_last)) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
        end else if (off_ready) begin
          w_advance = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The first beat is computed from the command itself so it is valid one cycle after accept.
  assign w_op_sel   = (r_state == S_IDLE) ? cmd_op : r_op;
  assign w_base_sel = (r_state == S_IDLE) ? cmd_base : r_base;

  always_comb begin
    w_nx = 3'd0;
    w_ny = 3'd0;
    if (r_state == S_RUN) begin
      if (r_x == 3'd4) begin
        w_nx = 3'd0;
        w_ny = r_y + 3'd1;
      end else begin
        w_nx = r_x + 3'd1;
        w_ny = r_y;
      end
    end
  end

  ssha3 u_ssha3 (
    .i_rs1  (w_nx),
    .i_rs2  (w_ny),
    .i_f_xy (w_op_sel == OP_XY),
    .i_f_x1 (w_op_sel == OP_X1),
    .i_f_x2 (w_op_sel == OP_X2),
    .i_f_x4 (w_op_sel == OP_X4),
    .i_f_yx (w_op_sel == OP_YX),
    .o_idx  (w_idx)
  );

  assign w_next_addr = w_base_sel + ADDR_W'({w_idx, 2'b00});
  assign w_next_last = (w_nx == 3'd4) && (w_ny == LAST_Y);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_op     <= 3'd0;
      r_base   <= '0;
      r_x      <= 3'd0;
      r_y      <= 3'd0;
      r_addr   <= '0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_err_op <= 1'b0;
    end else begin
      r_done   <= w_finish;
      r_err_op <= w_err;
      if (w_start) begin
        r_op   <= cmd_op;
        r_base <= cmd_base;
      end
      if (w_start || w_advance) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_addr <= w_next_addr;
        r_last <= w_next_last;
      end else if (w_finish) begin
        r_last <= 1'b0;
      end
    end
  end

  assign off_addr = r_addr;
  assign off_x    = r_x;
  assign off_y    = r_y;
  assign off_last = r_last;
  assign done     = r_done;
  assign err_op   = r_err_op;

endmodule

// File: tb/tb_ssha3_seq.sv
// Directed bench for ssha3_seq: a ROWS=5 and a ROWS=2 instance share stimulus,
// selected by sel; walks are checked beat by beat against hand-computed addresses.

module tb_ssha3_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        cmd_valid;
  logic        cmd_abort;
  logic        off_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_base;

  logic        d1_cmd_valid, d1_cmd_abort, d1_off_ready;
  logic        d1_cmd_ready, d1_off_valid, d1_off_last, d1_done, d1_err_op;
  logic [31:0] d1_off_addr;
  logic [2:0]  d1_off_x, d1_off_y;
  logic        d2_cmd_valid, d2_cmd_abort, d2_off_ready;
  logic        d2_cmd_ready, d2_off_valid, d2_off_last, d2_done, d2_err_op;
  logic [31:0] d2_off_addr;
  logic [2:0]  d2_off_x, d2_off_y;

  logic        cmd_ready_o, off_valid_o, off_last_o, done_o, err_op_o;
  logic [31:0] off_addr_o;
  logic [2:0]  off_x_o, off_y_o;

  assign d1_cmd_valid = cmd_valid & ~sel;
  assign d1_cmd_abort = cmd_abort & ~sel;
  assign d1_off_ready = off_ready & ~sel;
  assign d2_cmd_valid = cmd_valid & sel;
  assign d2_cmd_abort = cmd_abort & sel;
  assign d2_off_ready = off_ready & sel;

  assign cmd_ready_o = sel ? d2_cmd_ready : d1_cmd_ready;
  assign off_valid_o = sel ? d2_off_valid : d1_off_valid;
  assign off_last_o  = sel ? d2_off_last  : d1_off_last;
  assign done_o      = sel ? d2_done      : d1_done;
  assign err_op_o    = sel ? d2_err_op    : d1_err_op;
  assign off_addr_o  = sel ? d2_off_addr  : d1_off_addr;
  assign off_x_o     = sel ? d2_off_x     : d1_off_x;
  assign off_y_o     = sel ? d2_off_y     : d1_off_y;

  ssha3_seq #(.ADDR_W(32), .ROWS(5)) u_dut5 (
    .g_clk(clk), .g_resetn(rst_n),
    .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_abort(d1_cmd_abort),
    .off_valid(d1_off_valid), .off_ready(d1_off_ready), .off_addr(d1_off_addr),
    .off_x(d1_off_x), .off_y(d1_off_y), .off_last(d1_off_last),
    .done(d1_done), .err_op(d1_err_op)
  );

  ssha3_seq #(.ADDR_W(32), .ROWS(2)) u_dut2 (
    .g_clk(clk), .g_resetn(rst_n),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_abort(d2_cmd_abort),
    .off_valid(d2_off_valid), .off_ready(d2_off_ready), .off_addr(d2_off_addr),
    .off_x(d2_off_x), .off_y(d2_off_y), .off_last(d2_off_last),
    .done(d2_done), .err_op(d2_err_op)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [2:0] op, input logic [31:0] base,
                                             input int x, input int y);
    int r;
    int idx;
    r = (2 * x + 3 * y) % 5;
    case (op)
      3'd0:    idx = x + 4 * r + y;
      3'd1:    idx = (x + 1) % 5 + 4 * r + y;
      3'd2:    idx = (x + 2) % 5 + 4 * r + y;
      3'd3:    idx = (x + 4) % 5 + 4 * r + y;
      3'd4:    idx = y + 5 * r;
      default: idx = 0;
    endcase
    return base + 32'(4 * idx);
  endfunction

  logic [2:0]  cur_op;
  logic [31:0] cur_base;

  int          w_beats, w_seq_err, w_addr_err, w_stall_err, w_last_cnt;
  int          w_last_idx, w_last_x, w_last_y, w_first_c, w_last_c, w_done_gap;
  bit          w_done_seen;
  logic [31:0] w_cap;

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] base);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cur_op    = op;
    cur_base  = base;
    for (int i = 0; i < 50 && !cmd_ready_o; i++) @(negedge clk);
    check("cmd_accept_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Consumes beats until done; called at the negedge right after send_cmd.
  task automatic walk(input bit rnd, input int tx, input int ty);
    int          ex, ey;
    bit          stalled, rdy;
    logic [2:0]  sx, sy;
    logic [31:0] sa;
    logic        sl;
    ex = 0; ey = 0; stalled = 0; sx = '0; sy = '0; sa = '0; sl = 1'b0;
    w_beats = 0; w_seq_err = 0; w_addr_err = 0; w_stall_err = 0; w_last_cnt = 0;
    w_last_idx = -1; w_last_x = -1; w_last_y = -1; w_first_c = -1; w_last_c = -1;
    w_done_gap = -1; w_done_seen = 0; w_cap = 32'hDEAD_BEEF;
    for (int c = 0; c < 600; c++) begin
      if (done_o) begin
        w_done_seen = 1;
        w_done_gap  = c - w_last_c;
        break;
      end
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      off_ready = rdy;
      if (off_valid_o) begin
        if (stalled && (off_x_o !== sx || off_y_o !== sy || off_addr_o !== sa || off_last_o !== sl))
          w_stall_err++;
        if (rdy) begin
          w_beats++;
          if (w_first_c < 0) w_first_c = c;
          w_last_c = c;
          if (int'(off_x_o) != ex || int'(off_y_o) != ey) w_seq_err++;
          if (off_addr_o !== model_addr(cur_op, cur_base, int'(off_x_o), int'(off_y_o))) w_addr_err++;
          if (off_last_o) begin
            w_last_cnt++;
            w_last_idx = w_beats;
            w_last_x   = int'(off_x_o);
            w_last_y   = int'(off_y_o);
          end
          if (int'(off_x_o) == tx && int'(off_y_o) == ty) w_cap = off_addr_o;
          stalled = 0;
          if (ex == 4) begin ex = 0; ey++; end else ex++;
        end else begin
          stalled = 1;
          sx = off_x_o; sy = off_y_o; sa = off_addr_o; sl = off_last_o;
        end
      end
      @(negedge clk);
    end
    off_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] base;
    int          x;
    int          y;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0]  = '{3'd0, 32'h0000_1000, 1, 0, 32'h0000_1024};
    vecs[1]  = '{3'd0, 32'h0000_1000, 4, 4, 32'h0000_1020};
    vecs[2]  = '{3'd4, 32'h0000_0000, 0, 0, 32'd0};
    vecs[3]  = '{3'd4, 32'h0000_0000, 1, 0, 32'd40};
    vecs[4]  = '{3'd4, 32'h0000_0000, 0, 1, 32'd64};
    vecs[5]  = '{3'd1, 32'h0000_0000, 4, 0, 32'd48};
    vecs[6]  = '{3'd3, 32'h0000_0000, 1, 0, 32'd32};
    vecs[7]  = '{3'd0, 32'hFFFF_FFF0, 1, 0, 32'h0000_0014};
    vecs[8]  = '{3'd2, 32'h0000_0000, 3, 2, 32'd40};
    vecs[9]  = '{3'd0, 32'h0000_0100, 0, 0, 32'h0000_0100};
    vecs[10] = '{3'd4, 32'h0000_0200, 4, 4, 32'h0000_0210};
    vecs[11] = '{3'd1, 32'h0000_0000, 2, 3, 32'd72};

    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_abort = 1'b0; off_ready = 1'b0;
    cmd_op = 3'd0; cmd_base = 32'd0; cur_op = 3'd0; cur_base = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_off_valid", 32'(off_valid_o), 32'd0);
    check("rst_off_addr",  off_addr_o, 32'd0);
    check("rst_off_xy",    {26'd0, off_x_o, off_y_o}, 32'd0);
    check("rst_off_last",  32'(off_last_o), 32'd0);
    check("rst_done_err",  {30'd0, done_o, err_op_o}, 32'd0);

    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check("idle_abort_done", 32'(done_o), 32'd0);
    check("idle_abort_ready", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send_cmd(vecs[i].op, vecs[i].base);
      check($sformatf("v%0d_first_valid", i), 32'(off_valid_o), 32'd1);
      walk(1'b0, vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_addr", i), w_cap, vecs[i].exp_addr);
      check($sformatf("v%0d_beats", i), 32'(w_beats), 32'd25);
      check($sformatf("v%0d_last_idx", i), 32'(w_last_idx), 32'd25);
      check($sformatf("v%0d_done_gap", i), 32'(w_done_gap), 32'd1);
      check($sformatf("v%0d_addr_err", i), 32'(w_addr_err), 32'd0);
      if (i == 0) begin
        check("v0_first_cycle", 32'(w_first_c), 32'd0);
        check("v0_last_cycle", 32'(w_last_c), 32'd24);
        check("v0_seq_err", 32'(w_seq_err), 32'd0);
        check("v0_last_cnt", 32'(w_last_cnt), 32'd1);
        check("v0_done_valid_low", 32'(off_valid_o), 32'd0);
        check("v0_done_ready", 32'(cmd_ready_o), 32'd1);
      end
    end

    for (int k = 0; k < 2; k++) begin
      send_cmd(k == 0 ? 3'd0 : 3'd4, k == 0 ? 32'h0000_1000 : 32'h0000_3000);
      walk(1'b1, -1, -1);
      check($sformatf("bp%0d_done_seen", k), 32'(w_done_seen), 32'd1);
      check($sformatf("bp%0d_beats", k), 32'(w_beats), 32'd25);
      check($sformatf("bp%0d_seq_err", k), 32'(w_seq_err), 32'd0);
      check($sformatf("bp%0d_addr_err", k), 32'(w_addr_err), 32'd0);
      check($sformatf("bp%0d_stall_err", k), 32'(w_stall_err), 32'd0);
      check($sformatf("bp%0d_last_idx", k), 32'(w_last_idx), 32'd25);
    end

    sel = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      send_cmd(3'd0, 32'h0000_0040);
      walk(k == 1, -1, -1);
      check($sformatf("r2_%0d_beats", k), 32'(w_beats), 32'd10);
      check($sformatf("r2_%0d_last_idx", k), 32'(w_last_idx), 32'd10);
      check($sformatf("r2_%0d_last_xy", k), 32'(w_last_x * 8 + w_last_y), 32'(4 * 8 + 1));
      check($sformatf("r2_%0d_seq_addr_err", k), 32'(w_seq_err + w_addr_err + w_stall_err), 32'd0);
      check($sformatf("r2_%0d_done_gap", k), 32'(w_done_gap), 32'd1);
    end
    sel = 1'b0;
    @(negedge clk);

    send_cmd(3'd0, 32'h0000_0500);
    off_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    off_ready = 1'b0;
    cmd_abort = 1'b1;
    check("abort_beat3_x", 32'(off_x_o), 32'd2);
    @(negedge clk);
    cmd_abort = 1'b0;
    check("abort_valid_low", 32'(off_valid_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd1);
    check("abort_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    check("abort_done_pulse", 32'(done_o), 32'd0);
    off_ready = 1'b1;
    n = 0;
    repeat (6) begin
      if (off_valid_o || done_o) n++;
      @(negedge clk);
    end
    off_ready = 1'b0;
    check("abort_no_more_beats", 32'(n), 32'd0);

    send_cmd(3'd6, 32'h0000_0000);
    check("resv_err_op", 32'(err_op_o), 32'd1);
    check("resv_no_valid", 32'(off_valid_o), 32'd0);
    check("resv_ready", 32'(cmd_ready_o), 32'd1);
    check("resv_no_done", 32'(done_o), 32'd0);
    @(negedge clk);
    check("resv_err_pulse", 32'(err_op_o), 32'd0);
    off_ready = 1'b1;
    n = 0;
    repeat (6) begin
      if (off_valid_o || done_o || !cmd_ready_o) n++;
      @(negedge clk);
    end
    off_ready = 1'b0;
    check("resv_quiet", 32'(n), 32'd0);

    send_cmd(3'd0, 32'h0000_0800);
    off_ready = 1'b1;
    repeat (7) @(negedge clk);
    check("mid_walk_xy", {26'd0, off_x_o, off_y_o}, {26'd0, 3'd2, 3'd1});
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(off_valid_o), 32'd0);
    check("mrst_ready", 32'(cmd_ready_o), 32'd1);
    check("mrst_xy", {26'd0, off_x_o, off_y_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    off_ready = 1'b0;
    @(negedge clk);
    send_cmd(3'd0, 32'h0000_0800);
    check("mrst_restart_xy", {26'd0, off_x_o, off_y_o}, 32'd0);
    check("mrst_restart_addr", off_addr_o, 32'h0000_0800);
    walk(1'b0, -1, -1);
    check("mrst_beats", 32'(w_beats), 32'd25);
    check("mrst_seq_err", 32'(w_seq_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
